sum_uart_tx: RTL and testbench
==============================

Name: sum_uart_tx

Overview:
Downstream consumer of the 8-bit adder result on the Tiny Tapeout top level. Buffers sums presented with a valid/ready handshake in a small FIFO. Serialises each sum out of one pin as a UART 8N1 frame, LSB first. The tx output is routed to a uo_out bit so the adder result can be read by a host over a serial line.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535; counter width is $clog2(CLKS_PER_BIT).
FIFO_DEPTH, 4, number of buffered sums; power of two, range 2..16.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
sum_in  input  8  byte to transmit (the adder output).
sum_valid  input  1  sum_in is valid this cycle.
sum_ready  output  1  FIFO can accept a byte; equals !full && !rst.
tx  output  1  UART serial line; idles high; registered.
busy  output  1  high when a frame is in progress or the FIFO is non-empty; registered.
overflow  output  1  sticky; set when sum_valid is high while sum_ready is low.

Behaviour:
- Reset (one clk edge with rst=1):
  - tx=1, busy=0, overflow=0.
  - FIFO emptied; FSM goes to IDLE; all counters cleared.
  - sum_ready=0 while rst is high.
  - Reset mid-frame aborts the frame immediately: tx=1 on the next edge. No partial bits are resumed.
- Push: at a rising edge with sum_valid && sum_ready, sum_in is written at the write pointer. Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked by a count register (0..FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop the head into shift register sh, clear baud_cnt, go to START, tx=0 on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles. Then tx=sh[0], set bit_idx=0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. Then shift sh right and increment bit_idx. After bit 7, go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go to START (tx=0) with no idle gap. Otherwise go to IDLE.
- Timing:
  - A byte pushed at edge N into an empty FIFO while in IDLE is popped at edge N+1. tx falls after edge N+1.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are contiguous.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, sum_ready=0, so a pop frees one slot on the next cycle.
- Overflow: a sum_valid while full sets overflow, and the byte is dropped. overflow clears only on rst.
- busy = (state != IDLE) || (count != 0). It is registered, updated on the same edge as the state and count.
- Data bits are sent LSB first. There is no parity bit and exactly one stop bit.

Test Plan:
- Reset: hold rst 3 cycles mid-traffic -> tx=1, busy=0, overflow=0, sum_ready=0 during rst and 1 the cycle after.
- Single byte, CLKS_PER_BIT=4: push 0xA5 at edge N -> tx low from N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. busy falls after 40 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two frames with no idle gap. Second start bit begins exactly 40 cycles after the first; the line is high for bits of the second frame.
- Full/overflow, FIFO_DEPTH=4: push 6 bytes 0x01..0x06 on consecutive cycles. 0x01 is popped at once, so 0x02..0x05 fill the FIFO and sum_ready drops. 0x06 is dropped and overflow=1. Transmitted sequence: 0x01..0x05.
- Simultaneous push/pop: with the FIFO holding 1 byte at the end of STOP, push 0x3C on that edge -> count stays 1 and 0x3C is sent after the current head.
- Reset mid-frame: assert rst during bit 3 of 0x5A -> tx=1 next cycle. After release, push 0x81 -> a clean frame with bits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/sum_uart_tx.sv
// UART 8N1 transmitter for adder sums, fed through a small valid/ready FIFO.
// Frames go out LSB first, back-to-back while the FIFO holds data.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_state_nx;
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [NW-1:0]   r_count, w_count_nx;
    logic [7:0]      r_sh, w_sh_nx;
    logic [CW-1:0]   r_baud, w_baud_nx;
    logic [2:0]      r_bit, w_bit_nx;
    logic            r_tx, w_tx_nx;
    logic            r_busy, r_ovf;
    logic            w_push, w_pop, w_empty, w_baud_end;

    assign w_empty    = (r_count == '0);
    assign sum_ready  = (r_count != FULL_CNT) && !rst;
    assign w_push     = sum_valid && sum_ready;
    assign w_baud_end = (r_baud == BAUD_LAST);

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_ovf;

    always_comb begin
        w_state_nx = r_state;
        w_sh_nx    = r_sh;
        w_baud_nx  = r_baud + 1'b1;
        w_bit_nx   = r_bit;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_nx   = 1'b1;
                w_baud_nx = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_sh_nx    = r_fifo[r_rd_ptr];
                    w_state_nx = START;
                    w_tx_nx    = 1'b0;
                end
            end
            START: begin
                if (w_baud_end) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_tx_nx    = r_sh[0];
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nx = STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        w_sh_nx  = r_sh >> 1;
                        w_tx_nx  = r_sh[1];
                        w_bit_nx = r_bit + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_sh_nx    = r_fifo[r_rd_ptr];
                        w_state_nx = START;
                        w_tx_nx    = 1'b0;
                    end else begin
                        w_state_nx = IDLE;
                        w_tx_nx    = 1'b1;
                    end
                end
            end
        endcase
        w_count_nx = r_count + NW'(w_push) - NW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= sum_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sh     <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_sh    <= w_sh_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= (w_state_nx != IDLE) || (w_count_nx != '0);
            if (sum_valid && !sum_ready) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: fixed vectors, directed frame scenarios and
// random traffic against a queue/frame-timer reference model.
module tb_sum_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sum_in = 8'h00;
    logic       sum_valid = 1'b0;
    logic       sum_ready, tx, busy, overflow;

    sum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: queue of pending bytes plus the frame on the wire.
    logic [7:0] q[$];
    bit         m_active = 0;
    int         m_t = 0;
    logic [9:0] m_frame = '1;
    bit         m_ovf = 0;

    // Line decoder
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    logic [7:0] rx_q[$];
    int         starts[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
        bit rdy;
        logic [7:0] b;
        rdy = !r && (q.size() < DEPTH);
        if (r) begin
            q.delete();
            m_active = 0;
            m_t = 0;
            m_ovf = 0;
        end else begin
            if (m_active && m_t == FLEN - 1) m_active = 0;
            else if (m_active) m_t++;
            if (!m_active && q.size() != 0) begin
                b = q.pop_front();
                m_frame = {1'b1, b, 1'b0};
                m_active = 1;
                m_t = 0;
            end
            if (v && rdy) q.push_back(d);
            if (v && !rdy) m_ovf = 1;
        end
    endtask

    task automatic decode(input bit r);
        int s;
        if (r) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx == 1'b0) begin
                rx_cnt = 1;
                rx_byte = '0;
                starts.push_back(cyc);
            end
        end else begin
            s = rx_cnt - CPB - CPB / 2;
            if (s >= 0 && s % CPB == 0 && s / CPB < 8) begin
                rx_byte[s / CPB] = tx;
                rx_cnt++;
            end else if (s == 8 * CPB) begin
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(rx_byte);
                rx_cnt = 0;
            end else begin
                rx_cnt++;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        logic etx;
        rst = r;
        sum_valid = v;
        sum_in = d;
        @(posedge clk);
        cyc++;
        model_edge(r, v, d);
        @(negedge clk);
        etx = m_active ? m_frame[m_t / CPB] : 1'b1;
        check("m_tx", 32'(tx), 32'(etx));
        check("m_busy", 32'(busy), 32'(m_active || q.size() != 0));
        check("m_ovf", 32'(overflow), 32'(m_ovf));
        check("m_ready", 32'(sum_ready), 32'(!r && q.size() < DEPTH));
        decode(r);
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            step(0, 0, 8'h00);
            i++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        step(0, 0, 8'h00);
    endtask

    task automatic check_rx(input string nm, input logic [7:0] exp[$]);
        check({nm, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < rx_q.size()) check(nm, 32'(rx_q[i]), 32'(exp[i]));
            else check(nm, 32'hdead, 32'(exp[i]));
        end
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        bit         etx;
        bit         ebusy;
        bit         eovf;
        bit         erdy;
    } vec_t;

    initial begin
        vec_t tbl[12];
        logic [7:0] exp[$];
        int pct;

        tbl = '{
            '{1, 0, 8'h00, 1, 0, 0, 0},
            '{1, 1, 8'h55, 1, 0, 0, 0},
            '{0, 1, 8'hA5, 1, 1, 0, 1},
            '{0, 0, 8'h00, 0, 1, 0, 1},
            '{0, 0, 8'h00, 0, 1, 0, 1},
            '{0, 0, 8'h00, 0, 1, 0, 1},
            '{0, 0, 8'h00, 0, 1, 0, 1},
            '{0, 0, 8'h00, 1, 1, 0, 1},
            '{0, 0, 8'h00, 1, 1, 0, 1},
            '{0, 0, 8'h00, 1, 1, 0, 1},
            '{0, 0, 8'h00, 1, 1, 0, 1},
            '{0, 0, 8'h00, 0, 1, 0, 1}
        };
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            check("t_tx", 32'(tx), 32'(tbl[i].etx));
            check("t_busy", 32'(busy), 32'(tbl[i].ebusy));
            check("t_ovf", 32'(overflow), 32'(tbl[i].eovf));
            check("t_ready", 32'(sum_ready), 32'(tbl[i].erdy));
        end
        drain(100);
        exp = '{8'hA5};
        check_rx("rx_single", exp);

        // Back-to-back frames
        rx_q.delete();
        starts.delete();
        step(0, 1, 8'h00);
        step(0, 1, 8'hFF);
        drain(200);
        exp = '{8'h00, 8'hFF};
        check_rx("rx_b2b", exp);
        check("b2b_starts", 32'(starts.size()), 32'd2);
        if (starts.size() == 2)
            check("b2b_gap", 32'(starts[1] - starts[0]), 32'(FLEN));

        // Fill to full, overflow drops the sixth byte
        rx_q.delete();
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, 8'(k));
            if (k == 5) check("full_ready", 32'(sum_ready), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        drain(400);
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("rx_full", exp);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset held 3 cycles in the middle of traffic
        step(0, 1, 8'h77);
        step(0, 1, 8'h78);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 8'h99);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
            check("rst_ready", 32'(sum_ready), 32'd0);
        end
        step(0, 0, 8'h00);
        check("post_rst_ready", 32'(sum_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Push lands on the same edge the stop bit ends and the head pops
        rx_q.delete();
        step(0, 1, 8'h11);
        step(0, 1, 8'h22);
        for (int i = 0; i < FLEN - 1; i++) step(0, 0, 8'h00);
        step(0, 1, 8'h3C);
        check("pp_tx", 32'(tx), 32'd0);
        check("pp_busy", 32'(busy), 32'd1);
        check("pp_ready", 32'(sum_ready), 32'd1);
        drain(300);
        exp = '{8'h11, 8'h22, 8'h3C};
        check_rx("rx_pushpop", exp);

        // Reset during bit 3 of 0x5A, then a clean frame
        rx_q.delete();
        step(0, 1, 8'h5A);
        for (int i = 0; i < 4 * CPB + 2; i++) step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        check("midrst_tx", 32'(tx), 32'd1);
        step(0, 0, 8'h00);
        check("midrst_idle", 32'(tx), 32'd1);
        step(0, 1, 8'h81);
        drain(100);
        exp = '{8'h81};
        check_rx("rx_midrst", exp);

        // Random traffic with varying load and rare resets
        for (int ph = 0; ph < 6; ph++) begin
            pct = (ph % 3 == 0) ? 3 : ((ph % 3 == 1) ? 10 : 40);
            for (int i = 0; i < 500; i++)
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pct,
                     8'($urandom));
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
